// File: rtl/iram_boot_ctrl.sv
// Boot sequencer for the soft CPU: owns the single IRAM port, hands it to the
// SPI loader during LOAD/FLUSH and to CPU instruction fetch during RUN.
module iram_boot_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int RST_HOLD = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ld_start_i,
  input  logic              ld_stop_i,
  input  logic              ld_byte_vld_i,
  input  logic [7:0]        ld_byte_data_i,
  input  logic              cpu_rd_en_i,
  input  logic [ADDR_W-1:0] cpu_rd_addr_i,
  output logic [15:0]       cpu_rd_data_o,
  output logic              cpu_rd_vld_o,
  output logic              cpu_rst_n_o,
  output logic              iram_en_o,
  output logic              iram_we_o,
  output logic [ADDR_W-1:0] iram_addr_o,
  output logic [15:0]       iram_wr_data_o,
  input  logic [15:0]       iram_rd_data_i,
  output logic              busy_o,
  output logic [ADDR_W:0]   ld_words_o,
  output logic              odd_err_o
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_HALT, S_LOAD, S_FLUSH, S_BOOT, S_RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                phase_q;
  logic [7:0]          low_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [ADDR_W:0]     words_q;
  logic                odd_q;
  logic                cpu_rst_n_q;
  logic                rd_pend_q;
  logic [15:0]         rd_hold_q;

  // Bytes arriving alongside either command pulse are dropped.
  logic byte_ok;
  assign byte_ok = ld_byte_vld_i && !ld_start_i && !ld_stop_i && (state_q == S_LOAD);

  // A fetch that lands in the same cycle as a reload command is discarded.
  assign cpu_rd_vld_o  = rd_pend_q && !ld_start_i;
  assign cpu_rd_data_o = cpu_rd_vld_o ? iram_rd_data_i : rd_hold_q;
  assign cpu_rst_n_o   = cpu_rst_n_q;
  assign busy_o        = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_BOOT);
  assign ld_words_o    = words_q;
  assign odd_err_o     = odd_q;

  always_comb begin
    iram_en_o      = 1'b0;
    iram_we_o      = 1'b0;
    iram_addr_o    = '0;
    iram_wr_data_o = '0;
    case (state_q)
      S_LOAD: begin
        if (byte_ok && phase_q) begin
          iram_en_o      = 1'b1;
          iram_we_o      = 1'b1;
          iram_addr_o    = ptr_q;
          iram_wr_data_o = {ld_byte_data_i, low_q};
        end
      end
      S_FLUSH: begin
        if (!ld_start_i) begin
          iram_en_o      = 1'b1;
          iram_we_o      = 1'b1;
          iram_addr_o    = ptr_q;
          iram_wr_data_o = {8'h00, low_q};
        end
      end
      S_RUN: begin
        if (cpu_rd_en_i && !ld_start_i) begin
          iram_en_o   = 1'b1;
          iram_addr_o = cpu_rd_addr_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_HALT;
      ptr_q       <= '0;
      phase_q     <= 1'b0;
      low_q       <= '0;
      hold_q      <= '0;
      words_q     <= '0;
      odd_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      rd_pend_q <= 1'b0;
      if (cpu_rd_vld_o) rd_hold_q <= iram_rd_data_i;
      if (ld_start_i) begin
        state_q     <= S_LOAD;
        ptr_q       <= '0;
        phase_q     <= 1'b0;
        words_q     <= '0;
        odd_q       <= 1'b0;
        cpu_rst_n_q <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (ld_stop_i) begin
              state_q <= phase_q ? S_FLUSH : S_BOOT;
              hold_q  <= HOLD_W'(RST_HOLD - 1);
            end else if (byte_ok) begin
              if (!phase_q) begin
                low_q   <= ld_byte_data_i;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                ptr_q   <= ptr_q + ADDR_W'(1);
                if (words_q != WORDS_MAX) words_q <= words_q + (ADDR_W+1)'(1);
              end
            end
          end
          S_FLUSH: begin
            phase_q <= 1'b0;
            odd_q   <= 1'b1;
            ptr_q   <= ptr_q + ADDR_W'(1);
            if (words_q != WORDS_MAX) words_q <= words_q + (ADDR_W+1)'(1);
            state_q <= S_BOOT;
            hold_q  <= HOLD_W'(RST_HOLD - 1);
          end
          S_BOOT: begin
            if (hold_q == '0) begin
              state_q     <= S_RUN;
              cpu_rst_n_q <= 1'b1;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
          S_RUN: rd_pend_q <= cpu_rd_en_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/iram_boot_ctrl.md
Name: iram_boot_ctrl

Overview:
- Sequences boot of the soft CPU from SPI-loaded instruction RAM.
- Owns the single IRAM port and multiplexes it between two masters:
  - the SPI loader during LOAD;
  - CPU instruction fetch during RUN.
- Packs loader bytes into 16-bit words and holds the CPU in reset until a load completes plus a programmable hold time.

Parameters:
- ADDR_W, 13, IRAM word-address width; depth = 2**ADDR_W words.
- RST_HOLD, 16, cycles cpu_rst_n_o stays low after load stop; minimum 1.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- ld_start_i  in  1  one-cycle pulse: begin load (decoded write-RAM-start command).
- ld_stop_i  in  1  one-cycle pulse: end load (decoded write-RAM-stop command).
- ld_byte_vld_i  in  1  loader data byte valid.
- ld_byte_data_i  in  8  loader data byte.
- cpu_rd_en_i  in  1  CPU fetch request.
- cpu_rd_addr_i  in  ADDR_W  CPU fetch word address.
- cpu_rd_data_o  out  16  fetch data.
- cpu_rd_vld_o  out  1  fetch data valid.
- cpu_rst_n_o  out  1  CPU reset, active low.
- iram_en_o  out  1  IRAM port enable.
- iram_we_o  out  1  IRAM write enable.
- iram_addr_o  out  ADDR_W  IRAM word address.
- iram_wr_data_o  out  16  IRAM write data.
- iram_rd_data_i  in  16  IRAM read data, valid 1 cycle after a read enable.
- busy_o  out  1  high in LOAD, FLUSH or BOOT.
- ld_words_o  out  ADDR_W+1  words written by the last or current load.
- odd_err_o  out  1  sticky: last load ended on an odd byte count.

Behaviour:
- Reset values:
  - State HALT.
  - cpu_rst_n_o=0.
  - All other outputs 0.
  - Internal write pointer 0, byte phase 0, hold counter 0.
- FSM states:
  - HALT: CPU held in reset. ld_start_i -> LOAD.
  - LOAD: loader owns the port.
  - FLUSH: write the pending odd byte.
  - BOOT: count RST_HOLD cycles.
  - RUN: CPU owns the port.
- ld_start_i handling:
  - Accepted in any state. Next state LOAD.
  - Pointer, byte phase, ld_words_o and odd_err_o cleared.
  - cpu_rst_n_o driven 0 the following cycle.
  - Any in-flight CPU fetch result is discarded: cpu_rd_vld_o=0 from that cycle on.
- Priority on a simultaneous pulse: ld_start_i wins over ld_stop_i. ld_byte_vld_i is ignored in any cycle where either pulse is high.
- LOAD byte packing:
  - Phase 0 byte is latched as the low byte.
  - Phase 1 byte forms the word {byte, low}. That same cycle: iram_en_o=1, iram_we_o=1, iram_addr_o=pointer.
  - After the write: pointer+1, ld_words_o+1.
- Pointer wrap: pointer wraps from 2**ADDR_W-1 to 0. ld_words_o saturates at 2**ADDR_W.
- ld_stop_i in LOAD:
  - Phase 1 pending -> FLUSH. FLUSH writes {8'h00, low} at pointer in one cycle, sets odd_err_o, increments ld_words_o, then goes to BOOT.
  - Otherwise -> BOOT directly.
- ld_stop_i outside LOAD is ignored.
- BOOT:
  - Counter loads RST_HOLD-1 on entry and decrements.
  - At 0 -> RUN. cpu_rst_n_o=1 from the first RUN cycle.
  - Total cpu_rst_n_o low time after the stop pulse = RST_HOLD cycles (+1 if FLUSH).
- RUN fetch path:
  - cpu_rd_en_i drives iram_en_o=1, iram_we_o=0, iram_addr_o=cpu_rd_addr_i combinationally.
  - cpu_rd_vld_o=1 and cpu_rd_data_o=iram_rd_data_i exactly 1 cycle later.
  - Back-to-back fetches sustain 1 per cycle.
- Ownership isolation:
  - Outside RUN, CPU requests are ignored: no IRAM access, no cpu_rd_vld_o.
  - Outside LOAD and FLUSH, iram_we_o is never 1.
- cpu_rd_data_o holds its last value when cpu_rd_vld_o=0.
- Async reset mid-load: all state is lost immediately and the CPU stays in reset until a new load completes.

Test Plan:
- Basic load and boot:
  - Stimulus: start; bytes 0x34,0x12,0x78,0x56; stop.
  - Required: writes 0x1234@0 and 0x5678@1; ld_words_o=2; odd_err_o=0; cpu_rst_n_o rises exactly 16 cycles after stop.
- Odd-byte load:
  - Stimulus: start; bytes 0xAA,0xBB,0xCC; stop.
  - Required: writes 0xBBAA@0 and 0x00CC@1 (FLUSH cycle); odd_err_o=1; ld_words_o=2.
- Fetch path:
  - Stimulus: in RUN, fetch addr 0 then 1 on consecutive cycles.
  - Required: cpu_rd_vld_o high on the next two cycles with 0x1234, then 0x5678; iram_we_o stays 0.
- Reload during RUN:
  - Stimulus: in RUN, pulse ld_start_i while a fetch is pending.
  - Required: cpu_rst_n_o=0 the next cycle; no cpu_rd_vld_o for that fetch; next byte pair written at address 0.
- Priority and ignored inputs:
  - Stimulus: ld_start_i and ld_stop_i pulsed together, plus a byte valid that cycle.
  - Required: state LOAD; byte ignored; pointer 0.
  - Stimulus: ld_stop_i pulsed in HALT.
  - Required: no effect.
- Wrap and reset mid-load:
  - Stimulus: with ADDR_W=2, load 10 words.
  - Required: writes cycle addresses 0..3,0..3,0,1; ld_words_o=4 (saturated).
  - Stimulus: async reset mid-load.
  - Required: cpu_rst_n_o=0 and busy_o=0 immediately.
